i2c_request_scheduler: RTL and testbench
========================================

# i2c_request_scheduler

- Sequences the I2C controller and shares it between two requesters: PC instructions arriving from the UART receive path, and periodic default temperature reads from an internal timer.
- Drives the instruction fields and the `i2c_valid_instr` tag that the downstream I2C-to-UART arbiter uses to decide what is buffered and what is bypassed.
- Holds off PC instructions while that arbiter's buffer is full.

## Interface
- `PERIOD`, 24'd1_000_000: cycles between default temperature reads.
- `TEMP_ADDR`, 8'h00: register address used for default reads.
- `DEFER_LIMIT`, 4: consecutive PC grants allowed while a default read waits.
- `WD_CYCLES`, 16'd4096: watchdog limit in WAIT (only with the macro).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `pc_instr_valid` in 1: PC instruction offered.
- `pc_instr_ready` out 1: holding register empty; accept on valid&&ready.
- `pc_address` in 8: instruction register address.
- `pc_mode` in 8: op info; [3:0] one-hot 0001 rd1, 0010 rd2, 0100 wr1, 1000 wr2.
- `pc_wr_data` in 16: write payload.
- `full_i2cbuffer` in 1: arbiter buffer full; blocks PC issue.
- `i2c_busy` in 1: I2C controller busy.
- `i2c_done` in 1: one-cycle completion pulse from the controller.
- `i2c_start` out 1: one-cycle issue pulse.
- `i2c_instr_address` out 8: issued address.
- `i2c_op_info` out 8: issued mode.
- `i2c_wr_data` out 16: issued payload.
- `i2c_valid_instr` out 3: 3'b001 default read, 3'b011 PC instruction, 3'b000 none.
- `i2c_abort` out 1: watchdog abort pulse.
- `timeout_err` out 1: sticky watchdog flag, cleared only by reset.

## Operation
- **PC holding register:** one entry. Loads on valid&&ready. Freed on the cycle `i2c_done` completes a PC instruction.
- **Period counter:** counts 0..PERIOD-1 and wraps. At the terminal count it sets `default_pending`. A terminal count while already pending is coalesced, not queued. Pending clears when a default read is issued.
- **FSM states:** IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when `!i2c_busy` and a request is eligible.
  - ISSUE lasts exactly one cycle with `i2c_start`=1, then → WAIT.
  - WAIT → IDLE on `i2c_done`.
- **Eligibility and priority:**
  - A PC request is eligible when the holding register is full and `full_i2cbuffer`=0.
  - A default read is eligible when pending; it ignores `full_i2cbuffer`.
  - A PC request wins over a default read unless `defer_cnt`==DEFER_LIMIT; then the default read wins.
  - `defer_cnt` increments on each PC grant made while a default read is pending. It clears on a default grant or when nothing is pending, and saturates at DEFER_LIMIT.
- **Default read fields:** address=TEMP_ADDR, op_info=8'h02, wr_data=0, tag=3'b001.
- **PC fields:** copied from the holding register, tag=3'b011.
- **Output stability:** outputs are registered. Fields and tag are stable from ISSUE through the WAIT exit. Tag returns to 3'b000 in IDLE.
- **Done pulses:** `i2c_done` in IDLE or ISSUE is ignored.
- **Simultaneous events:** a PC handshake, a timer terminal count and `i2c_done` in the same cycle are all honoured independently.

## Timing
- **Reset values:** `pc_instr_ready`=1; `i2c_start`=0; `i2c_abort`=0; `timeout_err`=0; `i2c_valid_instr`=0; address, op_info and wr_data =0. State=IDLE, counters=0, pending=0.
- **PC issue latency:** handshake at edge E → ISSUE at E+1 (`i2c_start` high between E+1 and E+2), provided the controller is idle and the buffer is not full.
- **Freeing the holding register:** `i2c_done` sampled at edge D → IDLE and `pc_instr_ready`=1 from D. A new issue occurs at D+1 at the earliest.
- **Mid-transaction reset:** everything returns to reset values immediately. The holding register content and any pending default read are lost.

## Configuration
- **With `I2C_SCHED_WATCHDOG_EN` defined:** a counter runs in WAIT. Reaching WD_CYCLES without `i2c_done`:
  - pulses `i2c_abort` for one cycle;
  - sets `timeout_err`;
  - frees the holding register if the transaction was a PC instruction;
  - returns to IDLE.
- **Without the macro:** WAIT has no timeout, and `i2c_abort` and `timeout_err` are tied to 0.

## Test plan
- **Single PC instruction:** PC valid with address 8'h01, mode 8'h02, controller idle → `i2c_start` one edge after the handshake, tag 3'b011. `pc_instr_ready` is 0 until `i2c_done`.
- **Default read:** PERIOD=16 with no PC traffic → `i2c_start` every 16 cycles (plus completion time), tag 3'b001, address TEMP_ADDR, op_info 8'h02.
- **Buffer full:** `full_i2cbuffer`=1 with a PC request held and a default read pending → default issued, PC held. Dropping full → PC issued on the next IDLE.
- **Starvation limit:** continuous PC traffic, DEFER_LIMIT=4, default pending → exactly 4 PC grants, then the default read.
- **Watchdog:** with the macro defined and WD_CYCLES=8, no `i2c_done` → `i2c_abort` pulse 8 cycles into WAIT, `timeout_err`=1, `pc_instr_ready`=1.
- **Reset during WAIT:** `reset` asserted low mid-transaction → all outputs at reset values asynchronously. Stray `i2c_done` pulses after reset are ignored.

Source files
------------

// File: rtl/i2c_request_scheduler.sv
// ----------------------------------------------------------------------------
// i2c_request_scheduler
//
// Shares one I2C controller between two requesters:
//   * PC instructions arriving from the UART receive path, held in a one-entry
//     holding register until the controller has finished with them;
//   * periodic default temperature reads, requested by an internal free-running
//     period counter.
// Each issued transaction carries a tag on i2c_valid_instr so the downstream
// I2C-to-UART arbiter knows whether to buffer the result (PC instruction) or
// bypass it (default read). PC instructions are held off while that arbiter's
// buffer is full. Default reads are never blocked by the buffer, and a pending
// default read can be deferred by at most DEFER_LIMIT consecutive PC grants.
//
// Parameters:
//   PERIOD       cycles between default temperature reads
//   TEMP_ADDR    register address used for default reads
//   DEFER_LIMIT  consecutive PC grants allowed while a default read waits
//   WD_CYCLES    watchdog limit in WAIT (only with I2C_SCHED_WATCHDOG_EN)
//
// Ports:
//   clk                system clock
//   reset              asynchronous, active-low reset
//   pc_instr_valid     PC instruction offered
//   pc_instr_ready     holding register empty; accept on valid && ready
//   pc_address         PC instruction register address
//   pc_mode            PC op info; [3:0] one-hot rd1/rd2/wr1/wr2
//   pc_wr_data         PC write payload
//   full_i2cbuffer     arbiter buffer full; blocks PC issue
//   i2c_busy           I2C controller busy
//   i2c_done           one-cycle completion pulse from the controller
//   i2c_start          one-cycle issue pulse
//   i2c_instr_address  issued address
//   i2c_op_info        issued mode
//   i2c_wr_data        issued payload
//   i2c_valid_instr    3'b001 default read, 3'b011 PC instruction, 3'b000 none
//   i2c_abort          watchdog abort pulse
//   timeout_err        sticky watchdog flag, cleared only by reset
//
// Build option:
//   I2C_SCHED_WATCHDOG_EN  when defined, a watchdog aborts a transaction that
//                          sits in WAIT for WD_CYCLES cycles without i2c_done.
//                          When undefined, WAIT never times out and i2c_abort /
//                          timeout_err are tied low.
// ----------------------------------------------------------------------------
module i2c_request_scheduler #(
  parameter logic [23:0] PERIOD      = 24'd1_000_000,
  parameter logic [7:0]  TEMP_ADDR   = 8'h00,
  parameter int unsigned DEFER_LIMIT = 4,
  parameter logic [15:0] WD_CYCLES   = 16'd4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_instr_valid,
  output logic        pc_instr_ready,
  input  logic [7:0]  pc_address,
  input  logic [7:0]  pc_mode,
  input  logic [15:0] pc_wr_data,
  input  logic        full_i2cbuffer,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  output logic        i2c_start,
  output logic [7:0]  i2c_instr_address,
  output logic [7:0]  i2c_op_info,
  output logic [15:0] i2c_wr_data,
  output logic [2:0]  i2c_valid_instr,
  output logic        i2c_abort,
  output logic        timeout_err
);

  localparam logic [2:0]  TAG_NONE    = 3'b000;
  localparam logic [2:0]  TAG_DEFAULT = 3'b001;
  localparam logic [2:0]  TAG_PC      = 3'b011;
  localparam logic [7:0]  DEFAULT_OP  = 8'h02;

  localparam int DEFER_W = (DEFER_LIMIT < 2) ? 1 : $clog2(DEFER_LIMIT + 1);
  localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(DEFER_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // PC holding register
  logic        hold_full;
  logic [7:0]  hold_addr;
  logic [7:0]  hold_mode;
  logic [15:0] hold_data;

  // Default-read timer and starvation guard
  logic [23:0]        period_cnt;
  logic               period_tc;
  logic               default_pending;
  logic [DEFER_W-1:0] defer_cnt;

  // Which requester owns the transaction currently in flight
  logic cur_is_pc;

  logic pc_handshake;
  logic pc_eligible;
  logic default_wins;
  logic grant_pc;
  logic grant_def;
  logic wd_hit;
  logic wd_expire;
  logic hold_free;

  assign pc_instr_ready = ~hold_full;
  assign pc_handshake   = pc_instr_valid & ~hold_full;
  assign pc_eligible    = hold_full & ~full_i2cbuffer;
  assign period_tc      = (period_cnt == (PERIOD - 24'd1));

  // Once a default read has been passed over DEFER_LIMIT times in a row it
  // takes precedence over a waiting PC instruction.
  assign default_wins   = default_pending && (defer_cnt == DEFER_MAX);

  // The holding register is released when the controller finishes (or the
  // watchdog gives up on) a transaction that came from the PC.
  assign hold_free      = (state == WAIT) && cur_is_pc && (i2c_done || wd_expire);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and grant decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    grant_pc   = 1'b0;
    grant_def  = 1'b0;
    wd_expire  = 1'b0;
    case (state)
      IDLE: begin
        if (!i2c_busy) begin
          if (pc_eligible && !default_wins) begin
            grant_pc = 1'b1;
          end else if (default_pending) begin
            grant_def = 1'b1;
          end
          if (grant_pc || grant_def) begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (i2c_done) begin
          state_next = IDLE;
        end else if (wd_hit) begin
          wd_expire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC holding register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_addr <= 8'h00;
      hold_mode <= 8'h00;
      hold_data <= 16'h0000;
    end else if (hold_free) begin
      hold_full <= 1'b0;
    end else if (pc_handshake) begin
      hold_full <= 1'b1;
      hold_addr <= pc_address;
      hold_mode <= pc_mode;
      hold_data <= pc_wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Period counter and pending default read. A terminal count that lands
  // while a read is already pending simply leaves it pending; a terminal
  // count on the same edge as a default grant starts a fresh request.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt      <= 24'd0;
      default_pending <= 1'b0;
    end else begin
      if (period_tc) begin
        period_cnt <= 24'd0;
      end else begin
        period_cnt <= period_cnt + 24'd1;
      end

      if (period_tc) begin
        default_pending <= 1'b1;
      end else if (grant_def) begin
        default_pending <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter: counts PC grants made over a waiting default read.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      defer_cnt <= '0;
    end else if (grant_def || !default_pending) begin
      defer_cnt <= '0;
    end else if (grant_pc && (defer_cnt != DEFER_MAX)) begin
      defer_cnt <= defer_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered issue outputs. Fields and tag are captured on the grant edge
  // so they are valid together with i2c_start and stay put until WAIT exits;
  // only the tag is cleared on return to IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i2c_start         <= 1'b0;
      i2c_instr_address <= 8'h00;
      i2c_op_info       <= 8'h00;
      i2c_wr_data       <= 16'h0000;
      i2c_valid_instr   <= TAG_NONE;
      cur_is_pc         <= 1'b0;
    end else begin
      i2c_start <= grant_pc | grant_def;
      if (grant_pc) begin
        i2c_instr_address <= hold_addr;
        i2c_op_info       <= hold_mode;
        i2c_wr_data       <= hold_data;
        i2c_valid_instr   <= TAG_PC;
        cur_is_pc         <= 1'b1;
      end else if (grant_def) begin
        i2c_instr_address <= TEMP_ADDR;
        i2c_op_info       <= DEFAULT_OP;
        i2c_wr_data       <= 16'h0000;
        i2c_valid_instr   <= TAG_DEFAULT;
        cur_is_pc         <= 1'b0;
      end else if ((state == WAIT) && (state_next == IDLE)) begin
        i2c_valid_instr   <= TAG_NONE;
      end
    end
  end

`ifdef I2C_SCHED_WATCHDOG_EN
  // --------------------------------------------------------------------------
  // Watchdog: counts cycles spent in WAIT. It is zero on entry to WAIT, so
  // the abort fires on the WD_CYCLES-th edge spent waiting.
  // --------------------------------------------------------------------------
  logic [15:0] wd_cnt;

  assign wd_hit = (wd_cnt == (WD_CYCLES - 16'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= 16'd0;
      i2c_abort   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      i2c_abort <= wd_expire;
      if (wd_expire) begin
        timeout_err <= 1'b1;
      end
      if ((state == WAIT) && !i2c_done && !wd_expire) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else begin
        wd_cnt <= 16'd0;
      end
    end
  end
`else
  // Without the watchdog WAIT only ends on i2c_done. WD_CYCLES is folded into
  // a constant-false term so the parameter stays referenced in this build.
  assign wd_hit      = 1'b0 && (WD_CYCLES != 16'd0);
  assign i2c_abort   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_request_scheduler.sv
// ----------------------------------------------------------------------------
// tb_i2c_request_scheduler
//
// Self-checking bench for i2c_request_scheduler with PERIOD=16, DEFER_LIMIT=4
// and WD_CYCLES=8. A responder process plays the I2C controller; a monitor
// pops the expected transaction from a queue on every i2c_start and compares
// the issued fields, and also logs the cycle (counted from reset release) at
// which each issue happened.
// ----------------------------------------------------------------------------
module tb_i2c_request_scheduler;

  localparam logic [7:0] TEMP_ADDR = 8'h4C;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  op;
    logic [15:0] data;
    logic [2:0]  tag;
  } issue_t;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  mode;
    logic [15:0] data;
    logic [2:0]  expTag;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_instr_valid = 1'b0;
  logic        pc_instr_ready;
  logic [7:0]  pc_address = 8'h00;
  logic [7:0]  pc_mode = 8'h00;
  logic [15:0] pc_wr_data = 16'h0000;
  logic        full_i2cbuffer = 1'b0;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_start;
  logic [7:0]  i2c_instr_address;
  logic [7:0]  i2c_op_info;
  logic [15:0] i2c_wr_data;
  logic [2:0]  i2c_valid_instr;
  logic        i2c_abort;
  logic        timeout_err;

  logic respBusy = 1'b0;
  logic busyHold = 1'b0;
  logic respDone = 1'b0;
  logic strayDone = 1'b0;
  bit   respEnable = 1'b1;
  int   doneDelay = 2;
  int   busyTail = 0;

  int total = 0;
  int bad = 0;
  int cycle = 0;

  issue_t expQ[$];
  int     startLog[$];

  assign i2c_busy = respBusy | busyHold;
  assign i2c_done = respDone | strayDone;

  i2c_request_scheduler #(
    .PERIOD      (24'd16),
    .TEMP_ADDR   (TEMP_ADDR),
    .DEFER_LIMIT (4),
    .WD_CYCLES   (16'd8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_instr_valid    (pc_instr_valid),
    .pc_instr_ready    (pc_instr_ready),
    .pc_address        (pc_address),
    .pc_mode           (pc_mode),
    .pc_wr_data        (pc_wr_data),
    .full_i2cbuffer    (full_i2cbuffer),
    .i2c_busy          (i2c_busy),
    .i2c_done          (i2c_done),
    .i2c_start         (i2c_start),
    .i2c_instr_address (i2c_instr_address),
    .i2c_op_info       (i2c_op_info),
    .i2c_wr_data       (i2c_wr_data),
    .i2c_valid_instr   (i2c_valid_instr),
    .i2c_abort         (i2c_abort),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  // Cycle number counted from reset release: the first edge after release is 1.
  always @(posedge clk or negedge reset) begin
    if (!reset) cycle <= 0;
    else        cycle <= cycle + 1;
  end

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endfunction

  // Scoreboard monitor: every issue pulse must match the oldest expectation.
  initial begin
    issue_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && i2c_start === 1'b1) begin
        startLog.push_back(cycle);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_tag",  32'(i2c_valid_instr),   32'(e.tag));
          checkOutput("sb_addr", 32'(i2c_instr_address), 32'(e.addr));
          checkOutput("sb_op",   32'(i2c_op_info),       32'(e.op));
          checkOutput("sb_data", 32'(i2c_wr_data),       32'(e.data));
        end
      end
    end
  end

  // Controller model: busy from the issue pulse, done after doneDelay cycles,
  // optionally staying busy for busyTail cycles after done.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && i2c_start === 1'b1 && respEnable) begin
        respBusy = 1'b1;
        repeat (doneDelay) @(negedge clk);
        respDone = 1'b1;
        @(negedge clk);
        respDone = 1'b0;
        repeat (busyTail) @(negedge clk);
        respBusy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL sim_timeout: got no finish, wanted finish before 300000");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic expectDefault();
    issue_t e;
    e.addr = TEMP_ADDR; e.op = 8'h02; e.data = 16'h0000; e.tag = 3'b001;
    expQ.push_back(e);
  endtask

  // Offer one PC instruction and return just after the handshake edge.
  task automatic applyStimulus(input vec_t v);
    issue_t e;
    int guard = 0;
    e.addr = v.addr; e.op = v.mode; e.data = v.data; e.tag = v.expTag;
    expQ.push_back(e);
    @(negedge clk);
    pc_instr_valid = 1'b1;
    pc_address = v.addr;
    pc_mode = v.mode;
    pc_wr_data = v.data;
    while (pc_instr_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (pc_instr_ready !== 1'b1) checkOutput("handshake_timeout", 32'(pc_instr_ready), 32'd1);
    @(posedge clk);
    #1;
    pc_instr_valid = 1'b0;
  endtask

  task automatic waitReady();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (pc_instr_ready !== 1'b1 && guard < 200);
    if (pc_instr_ready !== 1'b1) checkOutput("ready_timeout", 32'(pc_instr_ready), 32'd1);
  endtask

  task automatic waitCycle(input int target);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cycle < target && guard < 500);
    if (cycle != target) checkOutput("wait_cycle", 32'(cycle), 32'(target));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},   32'(pc_instr_ready),    32'd1);
    checkOutput({tag, "_start"},   32'(i2c_start),         32'd0);
    checkOutput({tag, "_abort"},   32'(i2c_abort),         32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout_err),       32'd0);
    checkOutput({tag, "_tag"},     32'(i2c_valid_instr),   32'd0);
    checkOutput({tag, "_addr"},    32'(i2c_instr_address), 32'd0);
    checkOutput({tag, "_op"},      32'(i2c_op_info),       32'd0);
    checkOutput({tag, "_data"},    32'(i2c_wr_data),       32'd0);
  endtask

  // Reset, clear bench state, and return at the negedge of the release.
  task automatic doReset();
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pc_instr_valid = 1'b0;
    full_i2cbuffer = 1'b0;
    busyHold = 1'b0;
    strayDone = 1'b0;
    respEnable = 1'b1;
    doneDelay = 2;
    busyTail = 0;
    repeat (2) @(negedge clk);
    expQ.delete();
    startLog.delete();
    reset = 1'b1;
  endtask

  task automatic checkStartAt(input string name, input int idx, input int expCycle);
    if (startLog.size() > idx) checkOutput(name, 32'(startLog[idx]), 32'(expCycle));
    else checkOutput({name, "_missing"}, 32'(startLog.size()), 32'(idx + 1));
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    int starveCycles[6];
    int s0;

    vecs[0] = '{addr: 8'h01, mode: 8'h02, data: 16'h0000, expTag: 3'b011};
    vecs[1] = '{addr: 8'hFF, mode: 8'h01, data: 16'hFFFF, expTag: 3'b011};
    vecs[2] = '{addr: 8'h00, mode: 8'h04, data: 16'hA5A5, expTag: 3'b011};
    vecs[3] = '{addr: 8'h80, mode: 8'h08, data: 16'h5A5A, expTag: 3'b011};
    vecs[4] = '{addr: 8'h7E, mode: 8'h08, data: 16'h0001, expTag: 3'b011};
    vecs[5] = '{addr: 8'hC3, mode: 8'h04, data: 16'h8000, expTag: 3'b011};
    starveCycles = '{19, 23, 27, 31, 35, 39};

    // Power-on reset values
    repeat (2) @(negedge clk);
    checkResetValues("por");

    // Single PC instructions from the table, each from a fresh reset so the
    // period timer cannot interleave a default read.
    for (int i = 0; i < 6; i++) begin
      doReset();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_start_early", i), 32'(i2c_start), 32'd0);
      checkOutput($sformatf("v%0d_ready_held", i), 32'(pc_instr_ready), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_start_latency", i), 32'(i2c_start), 32'd1);
      @(negedge clk);
      checkOutput($sformatf("v%0d_start_pulse", i), 32'(i2c_start), 32'd0);
      checkOutput($sformatf("v%0d_tag_wait", i), 32'(i2c_valid_instr), 32'(vecs[i].expTag));
      checkOutput($sformatf("v%0d_ready_wait", i), 32'(pc_instr_ready), 32'd0);
      waitReady();
      checkOutput($sformatf("v%0d_tag_idle", i), 32'(i2c_valid_instr), 32'd0);
    end

    // Default reads with no PC traffic: issues at cycles 17 and 33.
    doReset();
    expectDefault();
    expectDefault();
    waitCycle(40);
    checkStartAt("default_first", 0, 17);
    checkStartAt("default_second", 1, 33);
    checkOutput("default_count", 32'(startLog.size()), 32'd2);

    // Buffer full: default issued, PC held until the buffer drains.
    doReset();
    full_i2cbuffer = 1'b1;
    expectDefault();
    v = '{addr: 8'h33, mode: 8'h04, data: 16'hBEEF, expTag: 3'b011};
    applyStimulus(v);
    waitCycle(24);
    checkOutput("full_pc_held", 32'(pc_instr_ready), 32'd0);
    checkStartAt("full_default_first", 0, 17);
    checkOutput("full_one_issue", 32'(startLog.size()), 32'd1);
    full_i2cbuffer = 1'b0;
    waitReady();
    checkStartAt("full_pc_after_drain", 1, 25);

    // Starvation limit: four PC grants over a pending default, then the
    // default, then the next PC.
    doReset();
    doneDelay = 1;
    busyTail = 1;
    busyHold = 1'b1;
    v = '{addr: 8'h10, mode: 8'h01, data: 16'h0010, expTag: 3'b011};
    applyStimulus(v);
    waitCycle(18);
    busyHold = 1'b0;
    for (int k = 1; k < 5; k++) begin
      if (k == 4) expectDefault();
      v = '{addr: 8'(8'h10 + k), mode: 8'h02, data: 16'(16'h0010 + k), expTag: 3'b011};
      applyStimulus(v);
    end
    waitReady();
    for (int k = 0; k < 6; k++) begin
      checkStartAt($sformatf("starve_issue%0d", k), k, starveCycles[k]);
    end

    // Reset in the middle of WAIT, then a stray done pulse.
    doReset();
    respEnable = 1'b0;
    v = '{addr: 8'h77, mode: 8'h08, data: 16'h1234, expTag: 3'b011};
    applyStimulus(v);
    waitCycle(6);
    checkOutput("midwait_ready", 32'(pc_instr_ready), 32'd0);
    checkOutput("midwait_tag", 32'(i2c_valid_instr), 32'd3);
    s0 = startLog.size();
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("async_rst");
    @(negedge clk);
    reset = 1'b1;
    respEnable = 1'b1;
    @(negedge clk);
    strayDone = 1'b1;
    @(negedge clk);
    strayDone = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("stray_done_ready", 32'(pc_instr_ready), 32'd1);
    checkOutput("stray_done_tag", 32'(i2c_valid_instr), 32'd0);
    checkOutput("stray_done_no_issue", 32'(startLog.size()), 32'(s0));

    // Stuck transaction: watchdog abort 8 cycles into WAIT when built in,
    // otherwise the transaction simply stays in WAIT.
    doReset();
    respEnable = 1'b0;
    v = '{addr: 8'h21, mode: 8'h01, data: 16'h0000, expTag: 3'b011};
    applyStimulus(v);
`ifdef I2C_SCHED_WATCHDOG_EN
    waitCycle(11);
    checkOutput("wd_abort_before", 32'(i2c_abort), 32'd0);
    checkOutput("wd_timeout_before", 32'(timeout_err), 32'd0);
    @(negedge clk);
    checkOutput("wd_abort_pulse", 32'(i2c_abort), 32'd1);
    checkOutput("wd_timeout_set", 32'(timeout_err), 32'd1);
    checkOutput("wd_ready_freed", 32'(pc_instr_ready), 32'd1);
    checkOutput("wd_tag_idle", 32'(i2c_valid_instr), 32'd0);
    @(negedge clk);
    checkOutput("wd_abort_end", 32'(i2c_abort), 32'd0);
    checkOutput("wd_timeout_sticky", 32'(timeout_err), 32'd1);
`else
    waitCycle(12);
    checkOutput("nowd_abort", 32'(i2c_abort), 32'd0);
    checkOutput("nowd_timeout", 32'(timeout_err), 32'd0);
    checkOutput("nowd_still_waiting", 32'(pc_instr_ready), 32'd0);
    waitCycle(20);
    checkOutput("nowd_no_default", 32'(startLog.size()), 32'd1);
    checkOutput("nowd_tag_held", 32'(i2c_valid_instr), 32'd3);
`endif

    doReset();
    repeat (2) @(negedge clk);
    checkOutput("final_queue_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
